// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// hands one instruction at a time to decode over a valid/ready handshake.
module fetch_pc_unit #(
  parameter int unsigned      Width    = 32,
  parameter logic [Width-1:0] RESET_PC = '0,
  parameter int unsigned      TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [Width-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [Width-1:0] imem_rdata,
  output logic [Width-1:0] instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic [1:0]       PCsrc,
  input  logic [Width-1:0] ImmExt,
  input  logic [Width-1:0] ALUResult,
  output logic [Width-1:0] PC,
  output logic [Width-1:0] PCPlus4,
  output logic [1:0]       fault
);

  localparam int unsigned      CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(TIMEOUT - 1);
  localparam logic [Width-1:0] Nop = Width'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, REQ, VALID, HALT} state_t;
  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_TIMEOUT  = 2'b10
  } fault_t;

  state_t          state_q, state_d;
  fault_t          fault_q;
  logic [Width-1:0] pc_q, pc_next, instr_q;
  logic [CntW-1:0]  cnt_q;
  logic             timeout_hit, misaligned, accept;

  assign PCPlus4     = pc_q + Width'(4);
  assign timeout_hit = (cnt_q == CntLast);
  assign accept      = (state_q == VALID) && instr_ready;

  // Reserved PCsrc encoding 10 falls through to sequential fetch.
  always_comb begin
    case (PCsrc)
      2'b01:   pc_next = pc_q + ImmExt;
      2'b11:   pc_next = {ALUResult[Width-1:1], 1'b0};
      default: pc_next = PCPlus4;
    endcase
  end

  assign misaligned = (pc_next[1:0] != 2'b00);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: each combinational output gets a default before the case so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = REQ;
      REQ: begin
        if (imem_ack)         state_d = VALID;
        else if (timeout_hit) state_d = HALT;
      end
      VALID:   if (instr_ready) state_d = misaligned ? HALT : REQ;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      REQ:     imem_req    = 1'b1;
      VALID:   instr_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= Nop;
      fault_q <= FAULT_NONE;
      cnt_q   <= '0;
    end else begin
      if (state_q == REQ) begin
        if (imem_ack) begin
          instr_q <= imem_rdata;
          cnt_q   <= '0;
        end else if (timeout_hit) begin
          fault_q <= FAULT_TIMEOUT;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
      // A misaligned target halts with the PC still pointing at the culprit.
      if (accept) begin
        if (misaligned) fault_q <= FAULT_MISALIGN;
        else            pc_q    <= pc_next;
      end
    end
  end

  assign imem_addr = pc_q;
  assign PC        = pc_q;
  assign instr     = instr_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit: sequential fetch,
// backpressure, branches, wrap, misalignment, timeout and async reset.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  PCsrc;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [1:0]  fault;

  int n_checks = 0;
  int n_errors = 0;

  fetch_pc_unit #(.Width(32), .RESET_PC(32'h0), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .PCsrc(PCsrc), .ImmExt(ImmExt), .ALUResult(ALUResult),
    .PC(PC), .PCPlus4(PCPlus4), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first REQ cycle, 1 ns after the edge.
  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // From REQ: same-cycle ack, then check the instruction lands in VALID.
  task automatic fetch(input logic [31:0] word, input logic [31:0] pc_exp);
    check("req_in_req", {31'b0, imem_req}, 32'd1);
    check("addr_in_req", imem_addr, pc_exp);
    check("valid_in_req", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    check("instr", instr, word);
    check("valid", {31'b0, instr_valid}, 32'd1);
    check("req_in_valid", {31'b0, imem_req}, 32'd0);
    check("pc", PC, pc_exp);
    check("pcplus4", PCPlus4, pc_exp + 32'd4);
  endtask

  task automatic accept(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
    PCsrc = src;
    ImmExt = imm;
    ALUResult = alu;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = '0;
    instr_ready = 1'b0;
    PCsrc = 2'b00;
    ImmExt = '0;
    ALUResult = '0;

    // Reset state
    tick();
    tick();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_pc", PC, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_fault", {30'b0, fault}, 32'd0);
    check("rst_pcplus4", PCPlus4, 32'h4);
    rst = 1'b0;
    tick();

    // Straight-line fetch 0,4,8,C
    for (int i = 0; i < 4; i++) begin
      fetch(32'h1000_0000 + i, 32'(4 * i));
      accept(2'b00, 32'h0, 32'h0);
    end
    check("seq_addr_after", imem_addr, 32'h10);

    // Decode backpressure
    do_reset();
    fetch(32'h0050_0093, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_instr", instr, 32'h0050_0093);
      check("bp_pc", PC, 32'h0);
      check("bp_valid", {31'b0, instr_valid}, 32'd1);
      check("bp_req", {31'b0, imem_req}, 32'd0);
    end
    accept(2'b00, 32'h0, 32'h0);
    check("bp_next_addr", imem_addr, 32'h4);

    // Reserved PCsrc, branch back, jalr, wraparound
    fetch(32'h1111_1111, 32'h4);
    accept(2'b10, 32'h40, 32'h80);
    fetch(32'h2222_2222, 32'h8);
    accept(2'b01, 32'hFFFF_FFF8, 32'h0);
    fetch(32'h3333_3333, 32'h0);
    accept(2'b11, 32'h0, 32'h0000_0101);
    fetch(32'h4444_4444, 32'h100);
    accept(2'b01, 32'hFFFF_FEFC, 32'h0);
    fetch(32'h5555_5555, 32'hFFFF_FFFC);
    accept(2'b00, 32'h0, 32'h0);
    fetch(32'h6666_6666, 32'h0);
    accept(2'b00, 32'h0, 32'h0);

    // Misaligned target from PC=4
    fetch(32'h7777_7777, 32'h4);
    accept(2'b01, 32'h2, 32'h0);
    check("mis_fault", {30'b0, fault}, 32'd1);
    check("mis_valid", {31'b0, instr_valid}, 32'd0);
    check("mis_req", {31'b0, imem_req}, 32'd0);
    check("mis_pc", PC, 32'h4);
    imem_ack = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_req", {31'b0, imem_req}, 32'd0);
      check("halt_pc", PC, 32'h4);
      check("halt_fault", {30'b0, fault}, 32'd1);
    end

    // Timeout: no ack for 16 REQ cycles
    do_reset();
    for (int i = 0; i < 15; i++) tick();
    check("to_req16", {31'b0, imem_req}, 32'd1);
    check("to_fault16", {30'b0, fault}, 32'd0);
    tick();
    check("to_fault", {30'b0, fault}, 32'd2);
    check("to_req", {31'b0, imem_req}, 32'd0);
    check("to_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b1;
    tick();
    tick();
    check("to_hold_req", {31'b0, imem_req}, 32'd0);
    check("to_hold_fault", {30'b0, fault}, 32'd2);
    imem_ack = 1'b0;

    // Timeout variant: ack on the 16th cycle
    do_reset();
    for (int i = 0; i < 15; i++) tick();
    imem_ack = 1'b1;
    imem_rdata = 32'hCAFE_0001;
    tick();
    imem_ack = 1'b0;
    check("to16_fault", {30'b0, fault}, 32'd0);
    check("to16_valid", {31'b0, instr_valid}, 32'd1);
    check("to16_instr", instr, 32'hCAFE_0001);

    // Async reset mid-wait, then a stale ack in IDLE
    do_reset();
    fetch(32'h8888_8888, 32'h0);
    accept(2'b00, 32'h0, 32'h0);
    tick();
    tick();
    check("mw_pc_before", PC, 32'h4);
    #3;
    rst = 1'b1;
    #1;
    check("mw_req", {31'b0, imem_req}, 32'd0);
    check("mw_pc", PC, 32'h0);
    check("mw_instr", instr, 32'h0000_0013);
    check("mw_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check("stale_valid", {31'b0, instr_valid}, 32'd0);
    check("stale_instr", instr, 32'h0000_0013);
    fetch(32'h9999_9999, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the decode/control unit.
- Owns the program counter, issues requests to instruction memory over a req/ack handshake, and presents one instruction at a time to decode with a valid/ready handshake.
- Computes the next PC from the decode-side PCsrc selection, plus the immediate and ALU result.
- Detects misaligned targets and instruction-memory timeouts, then halts.

Parameters:
- Width, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles spent waiting for imem_ack before a fault is raised (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  Width  fetch address, equals PC.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  Width  fetched instruction word.
- instr  out  Width  registered instruction to decode.
- instr_valid  out  1  instr holds an unconsumed instruction.
- instr_ready  in  1  decode accepts instr this cycle.
- PCsrc  in  2  next-PC select from decode, sampled on accept.
- ImmExt  in  Width  sign-extended immediate, sampled on accept.
- ALUResult  in  Width  jalr target, sampled on accept.
- PC  out  Width  address of the current instr.
- PCPlus4  out  Width  PC+4, the link value for jal/jalr.
- fault  out  2  00 none, 01 misaligned target, 10 imem timeout.

Behaviour:
- States: IDLE, REQ, VALID, HALT.
- Reset (async, any state, mid-transaction included):
  - state=IDLE, PC=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, fault=00, timeout counter=0, imem_req=0.
  - A pending memory transaction is abandoned, and a late imem_ack after reset is ignored.
- IDLE: first clock after rst deasserts → REQ.
- REQ:
  - imem_req=1, imem_addr=PC.
  - On imem_ack (ack may arrive in the same cycle req is first raised): instr<=imem_rdata, counter<=0, → VALID.
  - Otherwise counter increments. When counter reaches TIMEOUT-1 without ack: fault<=10, → HALT.
- VALID:
  - instr_valid=1, imem_req=0; instr and PC hold stable while instr_ready=0.
  - On instr_valid&&instr_ready, next PC is computed from the inputs sampled that same cycle:
    - PCsrc 00 → PC+4.
    - 01 → PC+ImmExt.
    - 11 → {ALUResult[Width-1:1],1'b0}.
    - 10 (reserved) → PC+4.
  - If next PC bits[1:0]≠00: fault<=01, PC unchanged, → HALT.
  - Else PC<=next PC, → REQ.
- HALT:
  - imem_req=0, instr_valid=0, PC and fault hold.
  - Leaves only on rst.
- Arithmetic: all additions modulo 2^Width; wrap from 32'hFFFF_FFFC to 0 is legal.
- PCPlus4 = PC+4 combinationally at all times.
- Throughput: minimum 2 cycles per instruction (REQ with same-cycle ack, then VALID with instr_ready=1).
- No speculative fetch: imem_req is never asserted while instr_valid=1.
- imem_ack outside REQ is ignored.

Test Plan:
- Straight-line fetch:
  - Stimulus: reset, memory acks in the same cycle, instr_ready=1, PCsrc=00.
  - Required: imem_addr sequence 0,4,8,C; each instr appears one cycle after its request; instr_valid toggles 0/1.
- Decode backpressure:
  - Stimulus: instr_ready=0 for 5 cycles, with 32'h00500093 at PC=0.
  - Required: instr, PC=0 and instr_valid=1 stay stable; imem_req=0. Raise ready → next imem_addr=4.
- Branch/jal/jalr:
  - At PC=8 with PCsrc=01, ImmExt=32'hFFFF_FFF8 → next PC=0.
  - PCsrc=11 with ALUResult=32'h0000_0101 → next PC=32'h100.
  - PCPlus4=PC+4 throughout.
- Misaligned target:
  - Stimulus: PCsrc=01, ImmExt=2.
  - Required: fault=01, instr_valid=0, imem_req stays 0 forever, PC unchanged.
- Timeout:
  - Stimulus: TIMEOUT=16, imem_ack held 0.
  - Required: fault=10 after 16 REQ cycles; HALT entered.
  - Variant: ack on the 16th cycle → no fault, instruction accepted.
- Reset mid-wait:
  - Stimulus: assert rst asynchronously while in REQ, then send a stale ack after release.
  - Required: PC=0, imem_req=0 immediately; the stale ack is ignored in IDLE; the fetch restarts at 0.
